sobel_window_ctrl: RTL

- Frame/line sequencer for the 3x3 Sobel window front end. Sits between the pixel stream source and the two cascaded line delays plus the 3x3 window registers.
- Tracks column and row and gates the line-delay write/advance strobe (ld_valid). Re-zeroes the line-delay pointers at every line boundary (ld_rst) so the delay equals exactly LINE_WIDTH for non-power-of-two widths.
- Emits window-valid and framing markers for interior-only output (FRAME_HEIGHT-2 x LINE_WIDTH-2 windows).

---
 rtl/sobel_window_ctrl_if.sv | 31 +++
 rtl/sobel_window_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sobel_window_ctrl_if.sv
// Stream, window and status signals between the pixel source/window consumer
// and the Sobel window sequencer.
interface sobel_window_ctrl_if;
  logic pix_valid;
  logic pix_ready;
  logic pix_sof;
  logic pix_eol;
  logic out_ready;
  logic ld_valid;
  logic ld_rst;
  logic win_valid;
  logic win_sof;
  logic win_eol;
  logic win_eof;
  logic frame_done;
  logic err_line;
  logic err_sof;
  logic err_clr;

  modport master (
    output pix_valid, pix_sof, pix_eol, out_ready, err_clr,
    input  pix_ready, ld_valid, ld_rst, win_valid, win_sof, win_eol, win_eof,
           frame_done, err_line, err_sof
  );

  modport slave (
    input  pix_valid, pix_sof, pix_eol, out_ready, err_clr,
    output pix_ready, ld_valid, ld_rst, win_valid, win_sof, win_eol, win_eof,
           frame_done, err_line, err_sof
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// Frame/line sequencer for the 3x3 Sobel front end: tracks row/column, gates the
// line-delay strobes and flags interior windows with framing markers.
module sobel_window_ctrl #(
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic                clk,
  input  logic                rst,
  sobel_window_ctrl_if.slave  bus
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(FRAME_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_LGAP   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          win_sof_q, win_sof_d;
  logic          win_eol_q, win_eol_d;
  logic          win_eof_q, win_eof_d;
  logic          frame_done_q, frame_done_d;
  logic          err_line_q, err_line_d;
  logic          err_sof_q, err_sof_d;

  logic in_active;
  logic mid_sof;
  logic pix_ready;
  logic beat;
  logic col_at_last;
  logic line_end;
  logic len_err;
  logic wv_term;
  logic we_term;

  // Handshake decode: a sof seen in IDLE is held off one cycle so it lands as
  // the first beat of ACTIVE; a sof inside a frame is refused and aborts it.
  always_comb begin
    in_active   = (state_q == ST_ACTIVE);
    mid_sof     = in_active & bus.pix_valid & bus.pix_sof &
                  ((row_q != '0) | (col_q != '0));
    pix_ready   = 1'b0;
    case (state_q)
      ST_IDLE:   pix_ready = ~(bus.pix_valid & bus.pix_sof);
      ST_ACTIVE: pix_ready = (bus.out_ready | ~win_valid_q) & ~mid_sof;
      default:   pix_ready = 1'b0;
    endcase
    beat        = in_active & bus.pix_valid & pix_ready;
    col_at_last = (col_q == COL_LAST);
    line_end    = beat & (bus.pix_eol | col_at_last);
    len_err     = beat & (bus.pix_eol ^ col_at_last);
    wv_term     = (row_q >= ROW_TWO) & (col_q >= COL_TWO);
    we_term     = wv_term & (bus.pix_eol | col_at_last);
  end

  // Next-state, counters, window flags and sticky errors.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    win_valid_d  = win_valid_q;
    win_sof_d    = win_sof_q;
    win_eol_d    = win_eol_q;
    win_eof_d    = win_eof_q;
    err_line_d   = (err_line_q & ~bus.err_clr) | len_err;
    err_sof_d    = (err_sof_q & ~bus.err_clr) | mid_sof;

    case (state_q)
      ST_IDLE: begin
        if (bus.pix_valid & bus.pix_sof) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (mid_sof) begin
          state_d = ST_IDLE;
        end else if (line_end) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = ST_DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = ST_LGAP;
          end
        end else if (beat) begin
          col_d = col_q + CW'(1);
        end
      end
      ST_LGAP: begin
        state_d = ST_ACTIVE;
      end
      default: begin
        state_d      = ST_IDLE;
        row_d        = '0;
        frame_done_d = 1'b1;
      end
    endcase

    // A window presented while out_ready is low is held until it is taken.
    if (beat) begin
      win_valid_d = wv_term;
      win_sof_d   = (row_q == ROW_TWO) & (col_q == COL_TWO);
      win_eol_d   = we_term;
      win_eof_d   = we_term & (row_q == ROW_LAST);
    end else if (bus.out_ready) begin
      win_valid_d = 1'b0;
      win_sof_d   = 1'b0;
      win_eol_d   = 1'b0;
      win_eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_sof_q    <= 1'b0;
      win_eol_q    <= 1'b0;
      win_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
      err_line_q   <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_sof_q    <= win_sof_d;
      win_eol_q    <= win_eol_d;
      win_eof_q    <= win_eof_d;
      frame_done_q <= frame_done_d;
      err_line_q   <= err_line_d;
      err_sof_q    <= err_sof_d;
    end
  end

  assign bus.pix_ready  = pix_ready;
  assign bus.ld_valid   = beat;
  assign bus.ld_rst     = ~in_active;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_sof    = win_sof_q;
  assign bus.win_eol    = win_eol_q;
  assign bus.win_eof    = win_eof_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_line   = err_line_q;
  assign bus.err_sof    = err_sof_q;

endmodule
